// File: rtl/magic_dev_pkg.sv
// rtl/magic_dev_pkg.sv - shared types for the cosim magic-device read requester
package magic_dev_pkg;

  localparam int SEL_W  = 12;
  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_PUSH,
    ST_ERRPUSH
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } resp_entry_t;

endpackage

// File: rtl/magic_resp_fifo.sv
// rtl/magic_resp_fifo.sv - response queue between device capture and the core response port
module magic_resp_fifo
  import magic_dev_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = resp_entry_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output T                       head
);

  localparam int AW = $clog2(DEPTH);

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers are exactly AW bits wide, so DEPTH being a power of two gives free wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = empty ? T'('0) : r_mem[r_rd_ptr];

endmodule

// File: rtl/magic_device_requester.sv
// rtl/magic_device_requester.sv - credit-limited single-outstanding read requester for the magic device
module magic_device_requester
  import magic_dev_pkg::*;
#(
  parameter int SEL_W       = magic_dev_pkg::SEL_W,
  parameter int DATA_W      = magic_dev_pkg::DATA_W,
  parameter int NUM_SEL     = 4096,
  parameter int WAIT_CYCLES = 0,
  parameter int RESP_DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [SEL_W-1:0]  dev_read_select,
  output logic              dev_read_ready,
  input  logic              dev_read_valid,
  input  logic [DATA_W-1:0] dev_read_data,
  output logic [31:0]       rd_count
);

  localparam int CW = $clog2(RESP_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } entry_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [2:0]         r_wait;
  logic [DATA_W-1:0]  r_cap;
  logic               r_req_ready;
  logic               r_dev_ready;
  logic [31:0]        r_rd_count;

  logic               w_accept;
  logic               w_sel_bad;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CW-1:0]      w_cnt;
  logic [CW-1:0]      w_cnt_nxt;
  logic               w_credit_nxt;
  entry_t             w_push_entry;
  entry_t             w_head;

  assign w_accept  = req_valid && r_req_ready;
  assign w_sel_bad = (int'(req_sel) >= NUM_SEL);
  assign w_push    = ((r_state == ST_PUSH) || (r_state == ST_ERRPUSH)) && !w_full;
  assign w_pop     = !w_empty && resp_ready;

  // Occupancy as it will be after this edge; nothing is in flight whenever we sit in IDLE.
  assign w_cnt_nxt    = w_cnt + CW'(w_push) - CW'(w_pop);
  assign w_credit_nxt = (int'(w_cnt_nxt) < RESP_DEPTH);

  always_comb begin
    w_push_entry = '0;
    if (r_state == ST_PUSH) begin
      w_push_entry.data = r_cap;
    end else begin
      w_push_entry.err = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_wait      <= '0;
      r_cap       <= '0;
      r_req_ready <= 1'b0;
      r_dev_ready <= 1'b0;
      r_rd_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sel       <= req_sel;
            r_req_ready <= 1'b0;
            if (w_sel_bad) begin
              r_state <= ST_ERRPUSH;
            end else begin
              r_state     <= ST_ISSUE;
              r_dev_ready <= 1'b1;
            end
          end else begin
            r_req_ready <= w_credit_nxt;
          end
        end
        ST_ISSUE: begin
          if (dev_read_valid) begin
            r_dev_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              r_cap   <= dev_read_data;
              r_state <= ST_PUSH;
            end else begin
              r_wait  <= 3'(WAIT_CYCLES - 1);
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_wait == '0) begin
            r_cap   <= dev_read_data;
            r_state <= ST_PUSH;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        ST_PUSH: begin
          r_rd_count  <= r_rd_count + 1'b1;
          r_state     <= ST_IDLE;
          r_req_ready <= w_credit_nxt;
        end
        ST_ERRPUSH: begin
          r_state     <= ST_IDLE;
          r_req_ready <= w_credit_nxt;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_dev_ready <= 1'b0;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  magic_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .T     (entry_t)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_cnt),
    .head      (w_head)
  );

  assign req_ready       = r_req_ready;
  assign resp_valid      = !w_empty;
  assign resp_data       = w_head.data;
  assign resp_err        = w_head.err;
  assign dev_read_select = r_sel;
  assign dev_read_ready  = r_dev_ready;
  assign rd_count        = r_rd_count;

endmodule

// File: tb/tb_magic_device_requester.sv
// tb/tb_magic_device_requester.sv - randomized bench with a transaction-timing reference model
module tb_magic_device_requester;

  localparam int DEPTH = 4;
  localparam int NSEL  = 256;
  localparam logic [63:0] D1 = 64'hDEADBEEF_00000001;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [11:0] req_sel = '0;
  logic        resp_ready = 1'b0;
  logic        dev_read_valid = 1'b0;
  logic [63:0] dev_read_data = '0;

  logic        req_ready       [2];
  logic        resp_valid      [2];
  logic [63:0] resp_data       [2];
  logic        resp_err        [2];
  logic [11:0] dev_read_select [2];
  logic        dev_read_ready  [2];
  logic [31:0] rd_count        [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: one pending transaction per instance, expressed as cycle numbers.
  bit          pend    [2];
  bit          perr    [2];
  int          t_iss   [2];
  int          hs      [2];
  int          push_at [2];
  logic [63:0] cap     [2];
  logic [11:0] lsel    [2];
  logic [31:0] cnt     [2];
  logic [64:0] mq0 [$];
  logic [64:0] mq1 [$];

  always #5 clock = ~clock;

  magic_device_requester #(.NUM_SEL(NSEL), .WAIT_CYCLES(0), .RESP_DEPTH(DEPTH)) u_w0 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_sel(req_sel), .resp_valid(resp_valid[0]), .resp_ready(resp_ready),
    .resp_data(resp_data[0]), .resp_err(resp_err[0]), .dev_read_select(dev_read_select[0]),
    .dev_read_ready(dev_read_ready[0]), .dev_read_valid(dev_read_valid),
    .dev_read_data(dev_read_data), .rd_count(rd_count[0])
  );

  magic_device_requester #(.NUM_SEL(NSEL), .WAIT_CYCLES(2), .RESP_DEPTH(DEPTH)) u_w2 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_sel(req_sel), .resp_valid(resp_valid[1]), .resp_ready(resp_ready),
    .resp_data(resp_data[1]), .resp_err(resp_err[1]), .dev_read_select(dev_read_select[1]),
    .dev_read_ready(dev_read_ready[1]), .dev_read_valid(dev_read_valid),
    .dev_read_data(dev_read_data), .rd_count(rd_count[1])
  );

  function automatic int wc(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [64:0] qhead(input int i);
    return (i == 0) ? mq0[0] : mq1[0];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic qpush(input int i, input logic [64:0] v);
    if (i == 0) mq0.push_back(v);
    else        mq1.push_back(v);
  endtask

  task automatic qpop(input int i);
    if (i == 0) void'(mq0.pop_front());
    else        void'(mq1.pop_front());
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; perr[i] = 1'b0; t_iss[i] = 0; hs[i] = -1;
      push_at[i] = -1; cap[i] = '0; lsel[i] = '0; cnt[i] = '0;
    end
    mq0.delete();
    mq1.delete();
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    req_valid = 1'b0; resp_ready = 1'b0; dev_read_valid = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("w%0d.rst.dev_read_ready", wc(i)), 64'(dev_read_ready[i]), 64'd0);
      check_eq($sformatf("w%0d.rst.req_ready", wc(i)), 64'(req_ready[i]), 64'd0);
      check_eq($sformatf("w%0d.rst.resp_valid", wc(i)), 64'(resp_valid[i]), 64'd0);
      check_eq($sformatf("w%0d.rst.resp_data", wc(i)), resp_data[i], 64'd0);
      check_eq($sformatf("w%0d.rst.resp_err", wc(i)), 64'(resp_err[i]), 64'd0);
      check_eq($sformatf("w%0d.rst.dev_read_select", wc(i)), 64'(dev_read_select[i]), 64'd0);
      check_eq($sformatf("w%0d.rst.rd_count", wc(i)), 64'(rd_count[i]), 64'd0);
    end
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance the model across the edge.
  task automatic step(input logic rv, input logic [11:0] sel, input logic rr,
                      input logic dv, input logic [63:0] dd);
    logic er [2];
    logic ed [2];
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      er[i] = !pend[i] && (qsize(i) < DEPTH);
      ed[i] = pend[i] && !perr[i] && (cyc >= t_iss[i]) && (hs[i] < 0);
      check_eq($sformatf("w%0d.req_ready", wc(i)), 64'(req_ready[i]), 64'(er[i]));
      check_eq($sformatf("w%0d.resp_valid", wc(i)), 64'(resp_valid[i]), 64'(qsize(i) != 0));
      if (qsize(i) != 0) begin
        check_eq($sformatf("w%0d.resp_data", wc(i)), resp_data[i], qhead(i)[63:0]);
        check_eq($sformatf("w%0d.resp_err", wc(i)), 64'(resp_err[i]), 64'(qhead(i)[64]));
      end
      check_eq($sformatf("w%0d.dev_read_ready", wc(i)), 64'(dev_read_ready[i]), 64'(ed[i]));
      if (ed[i]) begin
        check_eq($sformatf("w%0d.dev_read_select", wc(i)), 64'(dev_read_select[i]), 64'(lsel[i]));
      end
      check_eq($sformatf("w%0d.rd_count", wc(i)), 64'(rd_count[i]), 64'(cnt[i]));
    end
    req_valid = rv; req_sel = sel; resp_ready = rr;
    dev_read_valid = dv; dev_read_data = dd;
    for (int i = 0; i < 2; i++) begin
      if (ed[i] && dv) begin
        hs[i]      = cyc;
        push_at[i] = cyc + wc(i) + 1;
      end
      if (pend[i] && !perr[i] && hs[i] >= 0 && cyc == hs[i] + wc(i)) cap[i] = dd;
      if (qsize(i) != 0 && rr) qpop(i);
      if (push_at[i] == cyc) begin
        qpush(i, perr[i] ? {1'b1, 64'd0} : {1'b0, cap[i]});
        if (!perr[i]) cnt[i] = cnt[i] + 1;
        pend[i] = 1'b0;
        push_at[i] = -1;
      end
      if (er[i] && rv) begin
        pend[i] = 1'b1; lsel[i] = sel; t_iss[i] = cyc + 1; hs[i] = -1;
        perr[i] = (int'(sel) >= NSEL);
        if (perr[i]) push_at[i] = cyc + 1;
      end
    end
    cyc++;
  endtask

  initial begin
    model_reset();
    do_reset();
    repeat (2) step(1'b0, 12'h000, 1'b1, 1'b1, D1);

    step(1'b1, 12'h010, 1'b1, 1'b1, D1);
    repeat (8) step(1'b0, 12'h000, 1'b1, 1'b1, D1);

    step(1'b1, 12'hFFF, 1'b1, 1'b1, D1);
    repeat (4) step(1'b0, 12'h000, 1'b1, 1'b1, D1);

    step(1'b1, 12'h020, 1'b1, 1'b0, rnd64());
    repeat (5) step(1'b0, 12'h000, 1'b1, 1'b0, rnd64());
    repeat (8) step(1'b0, 12'h000, 1'b1, 1'b1, rnd64());

    repeat (30) step(1'b1, 12'($urandom_range(0, 255)), 1'b0, 1'b1, rnd64());
    repeat (12) step(1'b0, 12'h000, 1'b1, 1'b1, rnd64());

    step(1'b1, 12'h030, 1'b1, 1'b0, rnd64());
    repeat (2) step(1'b0, 12'h000, 1'b1, 1'b0, rnd64());
    do_reset();
    step(1'b1, 12'h040, 1'b1, 1'b1, rnd64());
    repeat (8) step(1'b0, 12'h000, 1'b1, 1'b1, rnd64());

    repeat (3000) begin
      step(1'($urandom_range(0, 1)), 12'($urandom_range(0, 511)),
           1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 6), rnd64());
    end
    repeat (20) step(1'b0, 12'h000, 1'b1, 1'b1, rnd64());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
